// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver (2-of-3 majority vote) feeding a first-word-fall-through FIFO.
// Optional even parity bit (8E1) when UART_RX_PARITY_EN is defined; default build is 8N1.
module uart_rx_fifo #(
  parameter int clk_freq   = 1000000,
  parameter int baud_rate  = 9600,
  parameter int os_rate    = 8,
  parameter int fifo_depth = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               rx,
  output logic [7:0]                         dout,
  output logic                               dout_valid,
  input  logic                               dout_ready,
  output logic                               frame_err,
  output logic                               parity_err,
  output logic                               overrun,
  output logic [$clog2(fifo_depth+1)-1:0]    fifo_count,
  output logic                               busy
);
  localparam int DIV = clk_freq / (baud_rate * os_rate);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OSW = $clog2(os_rate);
  localparam int AW  = $clog2(fifo_depth);
  localparam int CW  = $clog2(fifo_depth + 1);

  localparam logic [TW-1:0]  TICK_LAST = TW'(DIV - 1);
  localparam logic [OSW-1:0] OS_S0     = OSW'(os_rate / 2 - 1);
  localparam logic [OSW-1:0] OS_S1     = OSW'(os_rate / 2);
  localparam logic [OSW-1:0] OS_VOTE   = OSW'(os_rate / 2 + 1);
  localparam logic [OSW-1:0] OS_LAST   = OSW'(os_rate - 1);
  localparam logic [CW-1:0]  FULL_CNT  = CW'(fifo_depth);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t         state_q, state_d;
  logic           rxMeta_q, rxSync_q;
  logic [TW-1:0]  tickCnt_q, tickCnt_d;
  logic [OSW-1:0] osCnt_q, osCnt_d;
  logic [2:0]     bitIdx_q, bitIdx_d;
  logic [7:0]     shift_q, shift_d;
  logic           samp0_q, samp0_d, samp1_q, samp1_d;
  logic           armed_q, armed_d;
  logic           frameErr_q, frameErr_d;
  logic           overrun_q;
  logic           tick, voteEvt, bitEnd, voteBit, push;
`ifdef UART_RX_PARITY_EN
  logic           parErr_q, parErr_d;
  logic           parityErr_q, parityErr_d;
`endif

  logic [7:0]     mem_q [fifo_depth];
  logic [AW-1:0]  wrPtr_q, rdPtr_q;
  logic [CW-1:0]  count_q;
  logic           fifoFull, pop, wrEn;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= rx;
      rxSync_q <= rxMeta_q;
    end
  end

  assign tick    = (tickCnt_q == TICK_LAST);
  assign voteEvt = tick && (osCnt_q == OS_VOTE);
  assign bitEnd  = tick && (osCnt_q == OS_LAST);
  assign voteBit = (samp0_q & samp1_q) | (samp0_q & rxSync_q) | (samp1_q & rxSync_q);

  always_comb begin
    state_d    = state_q;
    tickCnt_d  = tick ? '0 : tickCnt_q + 1'b1;
    osCnt_d    = osCnt_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    samp0_d    = samp0_q;
    samp1_d    = samp1_q;
    armed_d    = armed_q;
    frameErr_d = 1'b0;
    push       = 1'b0;
`ifdef UART_RX_PARITY_EN
    parErr_d    = parErr_q;
    parityErr_d = 1'b0;
`endif
    if (tick) begin
      osCnt_d = (osCnt_q == OS_LAST) ? '0 : osCnt_q + 1'b1;
      if (osCnt_q == OS_S0) samp0_d = rxSync_q;
      if (osCnt_q == OS_S1) samp1_d = rxSync_q;
    end
    case (state_q)
      S_IDLE: begin
        if (rxSync_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          tickCnt_d = '0;
          osCnt_d   = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (voteEvt && voteBit) begin
          state_d = S_IDLE;
        end else if (bitEnd) begin
          bitIdx_d = '0;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (voteEvt) shift_d = {voteBit, shift_q[7:1]};
        if (bitEnd) begin
          if (bitIdx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bitIdx_d = bitIdx_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (voteEvt) parErr_d = (^shift_q) ^ voteBit;
        if (bitEnd) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // The stop vote ends the frame at once so a back-to-back start bit is never missed.
        if (voteEvt) begin
          state_d = S_IDLE;
          if (!voteBit) begin
            frameErr_d = 1'b1;
            armed_d    = 1'b0;
          end
`ifdef UART_RX_PARITY_EN
          else if (parErr_q) parityErr_d = 1'b1;
`endif
          else push = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tickCnt_q  <= '0;
      osCnt_q    <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      samp0_q    <= 1'b1;
      samp1_q    <= 1'b1;
      armed_q    <= 1'b1;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tickCnt_q  <= tickCnt_d;
      osCnt_q    <= osCnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      samp0_q    <= samp0_d;
      samp1_q    <= samp1_d;
      armed_q    <= armed_d;
      frameErr_q <= frameErr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      parErr_q    <= 1'b0;
      parityErr_q <= 1'b0;
    end else begin
      parErr_q    <= parErr_d;
      parityErr_q <= parityErr_d;
    end
  end
  assign parity_err = parityErr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign fifoFull   = (count_q == FULL_CNT);
  assign dout_valid = (count_q != '0);
  assign pop        = dout_valid && dout_ready;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the byte.
  assign wrEn       = push && (!fifoFull || pop);

  always_ff @(posedge clk) begin
    if (wrEn) mem_q[wrPtr_q] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wrEn) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop) rdPtr_q <= rdPtr_q + 1'b1;
      case ({wrEn, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      overrun_q <= push && fifoFull && !pop;
    end
  end

  assign dout       = dout_valid ? mem_q[rdPtr_q] : 8'h00;
  assign fifo_count = count_q;
  assign frame_err  = frameErr_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Oversampling UART receiver with majority-vote bit recovery, error detection, and a first-word-fall-through receive FIFO drained by a valid/ready handshake. It is the robust receive-side counterpart to the existing UART transmit path and plugs into the UART top level beside the transmitter. It synchronizes the raw `rx` line, rejects glitches and false starts, and buffers bytes so the consumer may stall for several frames.

## Interface
- `clk_freq`, 1000000: clock frequency in Hz.
- `baud_rate`, 9600: line rate in bit/s.
- `os_rate`, 8: samples per bit; must be ≥4. Tick divider `div = clk_freq/(baud_rate*os_rate)`, integer truncation, must be ≥1.
- `fifo_depth`, 4: FIFO entries; power of two, ≥2.

Ports:
- `clk` input 1: single clock; all logic rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `rx` input 1: asynchronous serial line, idle high.
- `dout` output 8: FIFO head byte; valid only while `dout_valid`=1.
- `dout_valid` output 1: FIFO not empty.
- `dout_ready` input 1: consumer accepts the head byte when `dout_valid`&&`dout_ready`.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled 0.
- `parity_err` output 1: one-cycle pulse when the parity check fails. Tied 0 without the macro.
- `overrun` output 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `fifo_count` output `$clog2(fifo_depth+1)`: current occupancy.
- `busy` output 1: state ≠ IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1) to give `rx_s`. All decisions use `rx_s`.
- Tick counter runs 0..div-1; it pulses `tick` at div-1 and is cleared on start detection. `os_cnt` advances 0..os_rate-1 per tick. A bit period ends at `os_cnt`=os_rate-1 on a tick.
- Samples are taken at `os_cnt` = os_rate/2-1, os_rate/2, and os_rate/2+1. The bit value is the 2-of-3 majority, resolved on the tick at os_rate/2+1 (the "vote").
- States:
  - IDLE: if armed and `rx_s`=0, clear the tick counter and `os_cnt`, then go to START. Armed is set when `rx_s`=1 is seen in IDLE and is set at reset.
  - START: vote=1 (false start) goes to IDLE with no error. Vote=0 continues to the end of the bit, then goes to DATA with bit index 0.
  - DATA: at each vote, shift the bit in LSB-first. After the 8th bit's period ends, go to PARITY (macro) or STOP.
  - PARITY: at vote, compare against even parity of the data. At bit end, go to STOP.
  - STOP: the vote finishes the frame immediately (no wait for bit end), then go to IDLE.
    - Vote=1 and no parity error: push the byte.
    - Vote=1 and parity error: drop the byte and pulse `parity_err`.
    - Vote=0: drop the byte, pulse `frame_err`, and clear armed so a break does not retrigger.
- FIFO:
  - Push when full with no pop in the same cycle: drop the new byte and pulse `overrun`. FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both happen, no overrun, count unchanged.
  - Push and pop in the same cycle while empty: not possible (FWFT, `dout_valid`=0).
  - Pointers wrap modulo `fifo_depth`.
- `rst` mid-frame aborts the frame, empties the FIFO, and returns to IDLE armed. No error pulses are generated.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, `fifo_count`=0, `busy`=0. Synchronizer flops reset to 1.
- Start detection occurs 2 cycles after the `rx` falling edge (synchronizer delay). `busy` rises the cycle after that.
- STOP vote cycle N: FIFO is written at edge N+1. `dout_valid`, `dout`, and `fifo_count` update in cycle N+1. Error pulses are high in cycle N+1 only.
- A pop takes effect at the edge where `dout_valid`&&`dout_ready`. The next entry, or `dout_valid`=0, appears in the following cycle.
- Error pulses are mutually exclusive per frame. Nominal frame length is 10 bits, or 11 with parity.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state exists, a 9th bit is expected as even parity (XOR of data and parity bit = 0), and `parity_err` is active.
- Not defined: no PARITY state, frames are 8N1, and `parity_err` is constant 0.

## Test plan
All scenarios use defaults: div=13, bit period 104 clocks.
- Send 0x55 8N1, `dout_ready`=1 → `dout_valid` one cycle with `dout`=0x55. No error pulses. `fifo_count` returns to 0.
- Pulse `rx` low for 20 clocks in IDLE → false start. `busy` returns to 0 within one bit period. No byte, no errors.
- Send 0xA3 with the stop bit held 0, then `rx` held low for 300 clocks, then 0x3C → one `frame_err` pulse, no retrigger during the break, then 0x3C received.
- `dout_ready`=0; send 0x01..0x06 → `fifo_count`=4, two `overrun` pulses. Raise `dout_ready` → pops 0x01,0x02,0x03,0x04.
- With `UART_RX_PARITY_EN`, send 0x07 with parity 1 (correct) and then with parity 0 → first byte stored, second gives a `parity_err` pulse and is dropped.
- Assert `rst` during DATA of 0xF0 with FIFO holding 2 bytes → next cycle all outputs are 0. A subsequent 0x0F is received cleanly.
